usb_rx_data_buffer: RTL

- Byte FIFO directly downstream of the USB receiver.
- Accepts decoded packet payload bytes when the receiver asserts store_rx_packet_data.
- Reports fill level back to the receiver and the AHB slave through buffer_occupancy.
- Drains one byte per get_rx_data request from the AHB-side register interface. Flush empties it at packet start or abort.

---
 rtl/usb_buf_pkg.sv | 7 +
 rtl/usb_buf_ram.sv | 27 ++
 rtl/usb_rx_data_buffer.sv | 104 ++++++++++
 3 files changed

// File: rtl/usb_buf_pkg.sv
// Shared types and defaults for the USB receive data buffer.
package usb_buf_pkg;
    localparam int DEPTH_DEFAULT = 64;

    typedef logic [7:0] byte_t;
    typedef logic [6:0] occ_t;
endpackage

// File: rtl/usb_buf_ram.sv
// DEPTH x 8 register array: synchronous write, combinational read.
module usb_buf_ram
    import usb_buf_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  byte_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output byte_t             rdata
);

    byte_t mem [DEPTH];

    // Contents are deliberately not reset; the occupancy counter decides validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Byte FIFO between the USB receiver and the AHB slave, with registered read data.
// Define USB_RX_BUF_ERR_EN to add sticky rx_overflow / rx_underflow outputs.
module usb_rx_data_buffer
    import usb_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       store_rx_packet_data,
    input  logic [7:0] rx_packet_data,
    input  logic       flush,
    input  logic       get_rx_data,
    output logic [7:0] rx_data,
`ifdef USB_RX_BUF_ERR_EN
    output logic       rx_overflow,
    output logic       rx_underflow,
`endif
    output logic [6:0] buffer_occupancy
);

    localparam int   ADDR_W    = $clog2(DEPTH);
    localparam occ_t DEPTH_OCC = occ_t'(DEPTH);

    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    occ_t              occ_reg;
    byte_t             rx_data_reg;
    byte_t             ram_rdata;
    logic              wr_ok;
    logic              rd_ok;

    // Acceptance uses pre-edge occupancy, so an empty buffer never falls through.
    assign wr_ok = store_rx_packet_data && (occ_reg < DEPTH_OCC);
    assign rd_ok = get_rx_data && (occ_reg != '0);

    usb_buf_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok && !flush),
        .waddr (wptr_reg),
        .wdata (rx_packet_data),
        .raddr (rptr_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            occ_reg     <= '0;
            rx_data_reg <= 8'h00;
        end else if (flush) begin
            // rx_data keeps the last byte read across a flush.
            wptr_reg <= '0;
            rptr_reg <= '0;
            occ_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rptr_reg    <= rptr_reg + 1'b1;
                rx_data_reg <= ram_rdata;
            end
            case ({wr_ok, rd_ok})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    assign rx_data          = rx_data_reg;
    assign buffer_occupancy = occ_reg;

`ifdef USB_RX_BUF_ERR_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (store_rx_packet_data && (occ_reg == DEPTH_OCC)) begin
                overflow_reg <= 1'b1;
            end
            if (get_rx_data && (occ_reg == '0)) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign rx_overflow  = overflow_reg;
    assign rx_underflow = underflow_reg;
`endif

endmodule
